// File: rtl/fifo_rd_stream_pkg.sv
// Shared FIFO read-stream definitions.
// Buffer geometry, read latency and occupancy encoding.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int RD_LAT    = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry ordered output buffer.
// Entry e0 is always the oldest word.
module fifo_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output occ_t              occ,
  output logic [DATA_W-1:0] head
);

  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] e0, e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      wr && !pop:
        occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
      !wr && pop:
        occ_d = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0 <= '0;
      e1 <= '0;
    end else begin
      unique case (1'b1)
        wr && !pop: begin
          if (occ_q == OCC_EMPTY) e0 <= wr_data;
          else                    e1 <= wr_data;
        end
        !wr && pop: e0 <= e1;
        wr && pop: begin
          // head leaves; new word lands behind whatever remains
          if (occ_q == OCC_TWO) begin
            e0 <= e1;
            e1 <= wr_data;
          end else begin
            e0 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = occ_q;
  assign head = e0;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO-to-stream adapter: issues pops, buffers words,
// and counts delivered beats.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  occ_t              occ;
  logic [RD_LAT-1:0] pend;
  logic              inflight;
  logic              pop;
  logic              run;
  logic [1:0]        level;

  assign inflight = pend[RD_LAT-1];
  assign m_valid  = (occ != OCC_EMPTY);
  assign pop      = m_valid && m_ready;
  assign level    = occ + {1'b0, inflight} - {1'b0, pop};
  // run holds rd_en off until the first edge out of reset
  assign rd_en    = run && !empty && (level < 2'(BUF_DEPTH));
  assign busy     = m_valid || inflight;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pend     <= '0;
      run      <= 1'b0;
      word_cnt <= '0;
    end else begin
      pend <= RD_LAT'({pend, rd_en});
      run  <= 1'b1;
      if (pop) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (rd_clk),
    .rst_n   (rd_rst_n),
    .wr      (inflight),
    .wr_data (rd_data),
    .pop     (pop),
    .occ     (occ),
    .head    (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a queue-based
// FIFO model and randomized ready/empty behaviour.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] word_cnt;
  logic          busy;

  fifo_rd_stream #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .empty    (empty),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            del_cyc[$];

  int mode      = 0;
  bit starve_en = 0;
  bit mon_on    = 0;
  int cyc       = 0;
  int issued    = 0;
  int delivered = 0;
  int model_cnt = 0;
  int first_rd  = -1;
  int first_vld = -1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock of FIFO + downstream behaviour.
  task automatic cycle();
    bit issue;
    @(negedge rd_clk);
    cyc++;
    empty = (fifo_q.size() == 0) ||
            (starve_en && $urandom_range(0, 3) == 0);
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      2:       m_ready = (cyc % 2) == 1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    issue = rd_en;
    if (issue) begin
      issued++;
      if (first_rd < 0) first_rd = cyc;
    end
    @(posedge rd_clk);
    #1;
    if (issue && fifo_q.size() > 0)
      rd_data = fifo_q.pop_front();
    else
      rd_data = DW'($urandom);
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    del_cyc.delete();
    issued    = 0;
    delivered = 0;
    model_cnt = 0;
    first_rd  = -1;
    first_vld = -1;
  endtask

  task automatic do_reset();
    mon_on = 0;
    @(negedge rd_clk);
    rd_rst_n = 1'b0;
    empty    = 1'b1;
    m_ready  = 1'b0;
    repeat (2) @(negedge rd_clk);
    clear_model();
    rd_rst_n = 1'b1;
    mon_on   = 1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < 400) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: pops expected words on each handshake.
  initial begin
    bit            p;
    bit            held = 0;
    logic [DW-1:0] held_data = '0;
    forever begin
      @(negedge rd_clk);
      #2;
      if (rd_rst_n && mon_on) begin
        p = m_valid && m_ready;
        chk("rd_en_while_empty", rd_en && empty, 0);
        chk("busy_vs_valid", m_valid && !busy, 0);
        chk("outstanding_le_2",
            (issued - delivered - int'(p)) > 2, 0);
        if (held) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, held_data);
        end
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (p) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", exp_q.size(), 1);
          end else begin
            chk("data", m_data, exp_q.pop_front());
            chk("word_cnt_run", word_cnt, model_cnt);
            model_cnt = (model_cnt + 1) % (1 << CW);
            delivered++;
            del_cyc.push_back(cyc);
          end
        end
        held      = m_valid && !m_ready;
        held_data = m_data;
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    logic [DW-1:0] w0;
    int            base;

    rd_rst_n = 1'b0;
    empty    = 1'b0;
    m_ready  = 1'b1;
    rd_data  = 8'hA5;
    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);

    // three words, ready high
    do_reset();
    load(8'h11); load(8'h22); load(8'h33);
    mode = 0;
    repeat (8) cycle();
    chk("first_latency", first_vld - first_rd, 2);
    chk("three_delivered", delivered, 3);
    if (del_cyc.size() == 3)
      chk("back_to_back", del_cyc[2] - del_cyc[0], 2);
    else
      chk("del_cyc_count", del_cyc.size(), 3);
    chk("cnt_three", word_cnt, 3);

    // stall: only two reads may be issued
    do_reset();
    for (int i = 0; i < 6; i++) load(DW'(8'h40 + i));
    w0   = 8'h40;
    mode = 1;
    base = issued;
    repeat (10) cycle();
    chk("stall_rd_en_pulses", issued - base, 2);
    chk("stall_head", m_data, w0);
    chk("stall_valid", m_valid, 1);
    mode = 0;
    drain();
    chk("stall_cnt", word_cnt, 6);

    // empty FIFO, toggling ready
    do_reset();
    mode = 2;
    repeat (12) cycle();
    chk("idle_issued", issued, 0);
    chk("idle_valid", m_valid, 0);
    chk("idle_busy", busy, 0);

    // alternating ready, eight words
    do_reset();
    for (int i = 0; i < 8; i++) load(DW'($urandom));
    mode = 2;
    drain();
    chk("alt_cnt", word_cnt, 8);
    chk("alt_delivered", delivered, 8);

    // counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) load(DW'(i * 3 + 1));
    mode = 0;
    drain();
    chk("wrap_cnt", word_cnt, 1);

    // asynchronous reset with a full buffer
    do_reset();
    for (int i = 0; i < 10; i++) load(DW'(8'h80 + i));
    mode = 0;
    repeat (3) cycle();
    mode = 1;
    repeat (4) cycle();
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_cnt_nz", word_cnt != 0, 1);
    @(negedge rd_clk);
    #3;
    mon_on   = 0;
    empty    = 1'b0;
    m_ready  = 1'b1;
    rd_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", word_cnt, 0);
    repeat (2) @(posedge rd_clk);
    #1;
    chk("held_rst_rd_en", rd_en, 0);
    @(negedge rd_clk);
    clear_model();
    for (int i = 0; i < 5; i++) load(DW'(8'hC0 + i));
    empty    = 1'b0;
    rd_rst_n = 1'b1;
    #1;
    chk("release_rd_en", rd_en, 0);
    mon_on = 1;
    mode   = 0;
    drain();
    chk("post_rst_cnt", word_cnt, 5);

    // random traffic
    do_reset();
    mode      = 3;
    starve_en = 1;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 20; i++) load(DW'($urandom));
      repeat ($urandom_range(5, 30)) cycle();
    end
    drain();
    starve_en = 0;
    chk("rand_cnt", word_cnt, model_cnt);
    chk("rand_delivered", delivered, 200);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of FIFO read data and stream data.
REQ-002 SHALL have parameter CNT_W, default 16, width of the delivered-word counter.
REQ-003 SHALL have port rd_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rd_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port empty  input  1  FIFO empty flag, rd_clk domain.
REQ-006 SHALL have port rd_data  input  DATA_W  FIFO read data, valid exactly 1 cycle after an accepted rd_en.
REQ-007 SHALL have port rd_en  output  1  FIFO pop request.
REQ-008 SHALL have port m_data  output  DATA_W  stream data.
REQ-009 SHALL have port m_valid  output  1  stream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port word_cnt  output  CNT_W  count of words delivered (m_valid && m_ready), wraps modulo 2^CNT_W.
REQ-012 SHALL have port busy  output  1  high when any word is in flight or buffered.

Function
REQ-013 SHALL hold a 2-entry output buffer (occupancy states EMPTY, ONE, TWO) plus one in-flight flag for the pending FIFO read.
REQ-014 SHALL compute pop = m_valid && m_ready, and drive rd_en = !empty && (occ + inflight - pop) < 2, combinationally.
REQ-015 SHALL never assert rd_en while empty is high.
REQ-016 SHALL set inflight for exactly the cycle after rd_en; in that cycle rd_data SHALL be written into the buffer.
REQ-017 Occupancy transitions: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-018 SHALL deliver words in FIFO order; m_data SHALL present the oldest buffered word and be stable while m_valid && !m_ready.
REQ-019 m_valid SHALL equal (occ != EMPTY); no bypass of rd_data to m_data in the write cycle (first-word latency: rd_en at cycle N -> m_valid at N+2).
REQ-020 SHALL sustain one word per cycle with m_ready held high and empty held low.
REQ-021 With m_ready low, SHALL stop issuing rd_en once occ + inflight = 2; no word SHALL be lost or overwritten.
REQ-022 busy SHALL equal (occ != EMPTY) || inflight.
REQ-023 word_cnt SHALL increment by 1 per pop, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-024 On rd_rst_n low, SHALL asynchronously clear occ to EMPTY, inflight, and word_cnt; outputs: rd_en 0, m_valid 0, m_data 0, word_cnt 0, busy 0.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight words; rd_en SHALL stay 0 while rd_rst_n is low.
REQ-026 SHALL resume issuing rd_en no earlier than the first rising edge after rd_rst_n deasserts.

Structure
REQ-027 Buffer depth (2) and read latency (1) SHALL be constants in the shared FIFO package; occupancy state encoding SHALL be a typedef there.
REQ-028 SHALL instantiate one sub-module, fifo_skid_buf (2-entry buffer with write/pop/occupancy); read-issue and counter logic remain in fifo_rd_stream.

Verification
REQ-029 FIFO holds 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, first m_valid 2 cycles after first rd_en, word_cnt=3.
REQ-030 Continuous non-empty FIFO, m_ready=0 for 10 cycles -> exactly 2 rd_en pulses, m_data held at first word; m_ready=1 -> order preserved, no loss.
REQ-031 empty=1 throughout, m_ready toggling -> rd_en never asserts, m_valid=0, busy=0.
REQ-032 m_ready pattern 1,0,1,0 with 8 words -> all 8 delivered in order, word_cnt=8, no rd_en while empty.
REQ-033 rd_rst_n pulsed low with occ=TWO and inflight=1 -> m_valid, rd_en, busy, word_cnt drop to 0 immediately; next rd_en after release.
REQ-034 CNT_W=4, 17 words delivered -> word_cnt wraps to 1.
